// File: rtl/wav_byte_fetch_if.sv
// Byte-read front end bus bundle: player byte port plus DDRAM toggle-handshake read port.
// Latency: none (wiring only).
// Backpressure: the player holds rd/rd_addr until rd_ready returns; DDRAM answers with an ack toggle.
// Ports: flush/rd_addr/rd/rd_data/rd_ready face the player; mem_addr/mem_rd/mem_ack/mem_dout face DDRAM.
// The slave modport is the fetch block's view; master is the environment's view.
interface wav_byte_fetch_if #(
  parameter int ADDR_W = 28
);
  logic              flush;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd;
  logic [7:0]        rd_data;
  logic              rd_ready;
  logic [ADDR_W-4:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [63:0]       mem_dout;

  modport slave (
    input  flush, rd_addr, rd, mem_ack, mem_dout,
    output rd_data, rd_ready, mem_addr, mem_rd
  );

  modport master (
    output flush, rd_addr, rd, mem_ack, mem_dout,
    input  rd_data, rd_ready, mem_addr, mem_rd
  );
endinterface

// File: rtl/wav_byte_fetch.sv
// Two-line byte cache with next-line prefetch between the WAV player and the DDRAM read port.
// Latency: hit served 2 cycles after the rd rise; miss served 1 cycle after the DDRAM ack toggle.
// Backpressure: rd_ready low while a request is in progress; one DDRAM request outstanding at a time.
// Ports: clk, reset_n (async, active low), bus (wav_byte_fetch_if.slave: player byte port + DDRAM port).
module wav_byte_fetch #(
  parameter int ADDR_W   = 28,
  parameter int PREFETCH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  wav_byte_fetch_if.slave       bus
);

  localparam int TAG_W = ADDR_W - 3;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_IDLE     = 3'd1,
    S_DEMAND   = 3'd2,
    S_PREFETCH = 3'd3,
    S_DRAIN    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               rd_q;
  logic               ack_last_q;
  logic               pend_q, pend_d;
  logic               rd_ready_q, rd_ready_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               mem_rd_q, mem_rd_d;
  logic [TAG_W-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]         vld_q, vld_d;
  logic [TAG_W-1:0]   tag_q [2];
  logic [TAG_W-1:0]   tag_d [2];
  logic [63:0]        dat_q [2];
  logic [63:0]        dat_d [2];
  logic               lru_q, lru_d;
  logic [TAG_W-1:0]   last_tag_q, last_tag_d;
  logic               last_vld_q, last_vld_d;

  logic               req_edge, ack_evt, hit0, hit1, pf_have, fill;
  logic [TAG_W-1:0]   req_tag, pf_tag;
  logic [5:0]         bit_sel;

  assign req_tag  = bus.rd_addr[ADDR_W-1:3];
  assign bit_sel  = {bus.rd_addr[2:0], 3'b000};
  assign req_edge = bus.rd & ~rd_q;
  assign ack_evt  = bus.mem_ack != ack_last_q;
  assign hit0     = vld_q[0] && (tag_q[0] == req_tag);
  assign hit1     = vld_q[1] && (tag_q[1] == req_tag);
  // Tag arithmetic is modulo the tag width, so the top line wraps to line 0.
  assign pf_tag   = last_tag_q + TAG_W'(1);
  assign pf_have  = (vld_q[0] && (tag_q[0] == pf_tag)) || (vld_q[1] && (tag_q[1] == pf_tag));

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    rd_ready_d = rd_ready_q;
    rd_data_d  = rd_data_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    vld_d      = vld_q;
    tag_d      = tag_q;
    dat_d      = dat_q;
    lru_d      = lru_q;
    last_tag_d = last_tag_q;
    last_vld_d = last_vld_q;
    fill       = 1'b0;

    if (bus.flush && (state_q != S_INIT)) begin
      // Flush beats a same-cycle request; an outstanding fetch must still have its ack consumed.
      vld_d      = 2'b00;
      pend_d     = 1'b0;
      rd_ready_d = 1'b1;
      last_vld_d = 1'b0;
      if ((state_q == S_DEMAND || state_q == S_PREFETCH || state_q == S_DRAIN) && !ack_evt)
        state_d = S_DRAIN;
      else
        state_d = S_IDLE;
    end else begin
      case (state_q)
        S_INIT: begin
          state_d = S_IDLE;
          if (req_edge) begin
            pend_d     = 1'b1;
            rd_ready_d = 1'b0;
          end
        end
        S_IDLE: begin
          if (pend_q) begin
            pend_d = 1'b0;
            if (hit0 || hit1) begin
              rd_data_d  = hit0 ? dat_q[0][bit_sel +: 8] : dat_q[1][bit_sel +: 8];
              rd_ready_d = 1'b1;
              lru_d      = hit0;   // replace the slot that was not just used
              last_tag_d = req_tag;
              last_vld_d = 1'b1;
            end else begin
              mem_addr_d = req_tag;
              mem_rd_d   = ~mem_rd_q;
              state_d    = S_DEMAND;
            end
          end else if (req_edge) begin
            pend_d     = 1'b1;
            rd_ready_d = 1'b0;
          end else if ((PREFETCH != 0) && last_vld_q && !pf_have) begin
            mem_addr_d = pf_tag;
            mem_rd_d   = ~mem_rd_q;
            state_d    = S_PREFETCH;
          end
        end
        S_DEMAND: begin
          if (ack_evt) begin
            fill       = 1'b1;
            rd_data_d  = bus.mem_dout[bit_sel +: 8];
            rd_ready_d = 1'b1;
            last_tag_d = mem_addr_q;
            last_vld_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
        S_PREFETCH, S_DRAIN: begin
          // A request here waits as pending; IDLE looks it up once the fetch has retired.
          if (req_edge) begin
            pend_d     = 1'b1;
            rd_ready_d = 1'b0;
          end
          if (ack_evt) begin
            fill    = (state_q == S_PREFETCH);
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (fill) begin
      vld_d[lru_q] = 1'b1;
      tag_d[lru_q] = mem_addr_q;
      dat_d[lru_q] = bus.mem_dout;
      lru_d        = ~lru_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      rd_q       <= 1'b0;
      ack_last_q <= 1'b0;
      pend_q     <= 1'b0;
      rd_ready_q <= 1'b1;
      rd_data_q  <= 8'h00;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      vld_q      <= 2'b00;
      tag_q[0]   <= '0;
      tag_q[1]   <= '0;
      dat_q[0]   <= '0;
      dat_q[1]   <= '0;
      lru_q      <= 1'b0;
      last_tag_q <= '0;
      last_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= bus.rd;
      // Tracking mem_ack every cycle: INIT adopts whatever polarity DDRAM came out of reset with,
      // and after an ack event the register already equals mem_ack.
      ack_last_q <= bus.mem_ack;
      pend_q     <= pend_d;
      rd_ready_q <= rd_ready_d;
      rd_data_q  <= rd_data_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      vld_q      <= vld_d;
      tag_q      <= tag_d;
      dat_q      <= dat_d;
      lru_q      <= lru_d;
      last_tag_q <= last_tag_d;
      last_vld_q <= last_vld_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_ready = rd_ready_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_wav_byte_fetch.sv
// Bench for wav_byte_fetch: directed scenarios plus randomized reads against a DDRAM model.
// Latency: DDRAM model answers LAT cycles after each mem_rd toggle.
// Backpressure: reads are held until rd_ready returns; every wait is bounded.
module tb_wav_byte_fetch;
  localparam int ADDR_W = 28;
  localparam int LAT    = 10;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  wav_byte_fetch_if #(.ADDR_W(ADDR_W)) ifc ();

  wav_byte_fetch #(.ADDR_W(ADDR_W), .PREFETCH(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference data: each byte address maps to a fixed pseudo-random byte.
  function automatic logic [7:0] model_byte(input logic [27:0] a);
    logic [7:0] m;
    m = a[7:0] * 8'd29;
    m = m ^ a[15:8] ^ a[23:16] ^ {4'h0, a[27:24]};
    return m + 8'h5A;
  endfunction

  function automatic logic [63:0] model_line(input logic [24:0] w);
    logic [63:0] l;
    l = '0;
    for (int n = 0; n < 8; n++) l[n*8 +: 8] = model_byte({w, 3'(n)});
    return l;
  endfunction

  // DDRAM model: one request at a time, ack toggle LAT cycles after the request toggle.
  logic [24:0] tog_addr[$];
  int          tog_cyc[$];
  int          ack_cyc_last = 0;
  bit          busy = 0;
  logic        rd_seen = 1'b0;
  int          cnt = 0;
  logic [24:0] cur = '0;

  initial begin
    ifc.mem_ack  = 1'b1;
    ifc.mem_dout = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        busy        = 0;
        rd_seen     = 1'b0;
        ifc.mem_ack = 1'b1;
      end else if (ifc.mem_rd !== rd_seen) begin
        rd_seen = ifc.mem_rd;
        chk("single_outstanding", {31'd0, busy}, 32'd0);
        busy = 1;
        cnt  = LAT;
        cur  = ifc.mem_addr;
        tog_addr.push_back(cur);
        tog_cyc.push_back(cyc);
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          ifc.mem_dout = model_line(cur);
          ifc.mem_ack  = ~ifc.mem_ack;
          busy         = 0;
          ack_cyc_last = cyc;
        end
      end
    end
  end

  function automatic logic [31:0] tog_at(input int i);
    return (i < tog_addr.size()) ? 32'(tog_addr[i]) : 32'hDEADBEEF;
  endfunction

  function automatic int tog_cyc_at(input int i);
    return (i < tog_cyc.size()) ? tog_cyc[i] : -1;
  endfunction

  // Request bookkeeping shared with the compare process.
  bit          req_live = 0;
  logic [27:0] req_addr = '0;
  int          req_t0 = 0;
  int          req_id = 0;
  int          served_id = 0;
  int          done_cyc = 0;

  // Compare process: rd_ready must drop at T+1 and the first ready after that carries the model byte.
  always @(negedge clk) begin
    if (reset_n && req_live && served_id != req_id) begin
      if (cyc == req_t0 + 1) begin
        chk("ready_drop", {31'd0, ifc.rd_ready}, 32'd0);
      end else if (cyc >= req_t0 + 2 && ifc.rd_ready) begin
        chk("rd_data", {24'd0, ifc.rd_data}, {24'd0, model_byte(req_addr)});
        done_cyc  = cyc;
        served_id = req_id;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_read(input logic [27:0] a);
    @(negedge clk);
    ifc.rd_addr = a;
    ifc.rd      = 1'b1;
    req_addr    = a;
    req_t0      = cyc;
    req_id++;
    req_live    = 1;
  endtask

  task automatic finish_read();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (served_id == req_id) begin
        ok = 1;
        break;
      end
    end
    chk("read_done", {31'd0, ok}, 32'd1);
    ifc.rd   = 1'b0;
    req_live = 0;
  endtask

  task automatic do_read(input logic [27:0] a);
    start_read(a);
    finish_read();
  endtask

  task automatic do_flush();
    @(negedge clk);
    req_live  = 0;
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    ifc.rd    = 1'b0;
    chk("flush_ready", {31'd0, ifc.rd_ready}, 32'd1);
  endtask

  task automatic wait_toggle(input int n);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (tog_addr.size() > n) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    chk("toggle_seen", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_quiet();
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    chk("ddram_quiet", {31'd0, ok}, 32'd1);
    idle(4);
  endtask

  initial begin
    int n;
    int bad;
    logic [24:0] line, prev_line;
    bit have_prev, same_line;

    reset_n     = 1'b0;
    ifc.rd      = 1'b0;
    ifc.flush   = 1'b0;
    ifc.rd_addr = '0;
    idle(3);
    chk("reset_rd_ready", {31'd0, ifc.rd_ready}, 32'd1);
    chk("reset_rd_data", {24'd0, ifc.rd_data}, 32'd0);
    chk("reset_mem_rd", {31'd0, ifc.mem_rd}, 32'd0);
    chk("reset_mem_addr", 32'(ifc.mem_addr), 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Sequential bytes 0x000..0x00F: demand for line 0, prefetch of line 1, then hits.
    do_read(28'h000);
    chk("seq_first_addr", tog_at(0), 32'h0);
    chk("seq_demand_lat", done_cyc, ack_cyc_last + 1);
    chk("seq_byte0_literal", {24'd0, ifc.rd_data}, 32'h5A);
    idle(16);
    chk("seq_prefetch_addr", tog_at(1), 32'h1);
    for (int a = 1; a < 16; a++) begin
      idle(16);
      do_read(28'(a));
      if (a >= 8) chk("seq_hit_lat", done_cyc - req_t0, 2);
    end
    chk("seq_toggle_count", tog_addr.size(), 3);
    chk("seq_prefetch2_addr", tog_at(2), 32'h2);

    // Miss latency on an empty cache.
    do_flush();
    wait_quiet();
    n = tog_addr.size();
    do_read(28'h1234);
    chk("miss_addr", tog_at(n), 32'h246);
    chk("miss_toggle_cyc", tog_cyc_at(n), req_t0 + 2);
    chk("miss_ready_cyc", done_cyc, ack_cyc_last + 1);
    chk("miss_byte_literal", {24'd0, ifc.rd_data}, 32'h50);

    // Request arriving while the prefetch of line 3 is outstanding.
    do_flush();
    wait_quiet();
    n = tog_addr.size();
    do_read(28'h010);
    wait_toggle(n + 1);
    chk("pf_line3_addr", tog_at(n + 1), 32'h3);
    do_read(28'h5000);
    chk("pf_then_demand_count", tog_addr.size() - (n + 1), 2);
    chk("pf_then_demand_addr", tog_at(n + 2), 32'hA00);
    chk("demand_after_pf_ack", {31'd0, tog_cyc_at(n + 2) > tog_cyc_at(n + 1) + LAT}, 32'd1);

    // Wrap of the prefetch address at the top line.
    do_flush();
    wait_quiet();
    n = tog_addr.size();
    do_read(28'hFFFFFFF);
    chk("wrap_demand_addr", tog_at(n), 32'h1FFFFFF);
    chk("wrap_byte_literal", {24'd0, ifc.rd_data}, 32'h46);
    wait_toggle(n + 1);
    chk("wrap_prefetch_addr", tog_at(n + 1), 32'h0);
    wait_quiet();
    do_read(28'h0000003);
    chk("wrap_hit_lat", done_cyc - req_t0, 2);
    chk("wrap_hit_literal", {24'd0, ifc.rd_data}, 32'hB1);
    chk("wrap_no_demand", tog_addr.size(), n + 2);

    // Flush while a demand is outstanding: late ack must not fill.
    do_flush();
    wait_quiet();
    n = tog_addr.size();
    start_read(28'h2000);
    wait_toggle(n);
    chk("flush_demand_addr", tog_at(n), 32'h400);
    idle(3);
    do_flush();
    wait_quiet();
    chk("drain_ready_held", {31'd0, ifc.rd_ready}, 32'd1);
    chk("drain_no_toggle", tog_addr.size(), n + 1);
    do_read(28'h2000);
    chk("reread_refetch", tog_at(n + 1), 32'h400);

    // Reset in the middle of a demand with mem_ack held high.
    do_flush();
    wait_quiet();
    n = tog_addr.size();
    start_read(28'h7008);
    wait_toggle(n);
    idle(2);
    @(negedge clk);
    req_live = 0;
    ifc.rd   = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midreset_ready", {31'd0, ifc.rd_ready}, 32'd1);
    chk("midreset_mem_rd", {31'd0, ifc.mem_rd}, 32'd0);
    idle(3);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("init_ready", {31'd0, ifc.rd_ready}, 32'd1);
    chk("init_mem_rd", {31'd0, ifc.mem_rd}, 32'd0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (!ifc.rd_ready || ifc.mem_rd) bad++;
    end
    chk("post_reset_quiet", bad, 0);
    chk("post_reset_no_toggle", tog_addr.size(), n + 1);
    do_read(28'h7008);
    chk("post_reset_refetch", tog_at(n + 1), 32'hE01);

    // Randomized reads over a few hot regions (one spans the tag wrap) with occasional flushes.
    have_prev = 0;
    prev_line = '0;
    for (int it = 0; it < 120; it++) begin
      int pick;
      if ($urandom_range(0, 99) < 8) begin
        do_flush();
        have_prev = 0;
      end
      pick = $urandom_range(0, 9);
      if (pick == 0) line = 25'($urandom);
      else if (pick < 4) line = 25'h1FFFFFD + 25'($urandom_range(0, 5));
      else line = 25'h100 + 25'($urandom_range(0, 5));
      if (have_prev && $urandom_range(0, 3) == 0) line = prev_line;
      same_line = have_prev && (line == prev_line);
      idle($urandom_range(0, 12));
      n = tog_addr.size();
      do_read({line, 3'($urandom_range(0, 7))});
      if (same_line) begin
        // The most recently served line is never the replacement victim.
        bad = 0;
        for (int i = n; i < tog_addr.size(); i++) if (tog_addr[i] == line) bad++;
        chk("retain_last_line", bad, 0);
      end
      prev_line = line;
      have_prev = 1;
    end
    wait_quiet();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wav_byte_fetch.md
Name: wav_byte_fetch

Overview:
- Byte-read front end for the WAV sample player.
- Sits between wave_sound's byte interface (address, read level, data, ready) and the DDRAM toggle-handshake read port (25-bit word address, 64-bit data, rd/ack toggles).
- Holds two 64-bit lines and prefetches the next sequential line, so steady-state sample reads are served without DDRAM latency.

Parameters:
- ADDR_W, 28, width of the byte address from the player; the line tag is ADDR_W-3 bits (25 at default).
- PREFETCH, 1, 1 enables next-line prefetch; 0 gives demand fetch only.

Ports:
- clk  in  1  system clock (clk_sys domain).
- reset_n  in  1  asynchronous reset, active low.
- flush  in  1  synchronous invalidate of both lines and cancel of any pending demand (asserted on WAV reload).
- rd_addr  in  ADDR_W  byte address; must be stable from the rd rise until rd_ready returns high.
- rd  in  1  read request level; a rising edge starts a request.
- rd_data  out  8  requested byte; valid while rd_ready=1 after a request.
- rd_ready  out  1  0 while a request is in progress, 1 otherwise.
- mem_addr  out  ADDR_W-3  DDRAM word address.
- mem_rd  out  1  request toggle.
- mem_ack  in  1  completion toggle; mem_dout is valid in the cycle mem_ack differs from its last sampled value.
- mem_dout  in  64  DDRAM line data; byte n = bits [8n+7:8n].

Behaviour:
- Reset values: rd_ready=1, rd_data=0, mem_rd=0, mem_addr=0, both slots invalid, state INIT.
- Storage: two slots, each {valid, tag[ADDR_W-4:0], data[63:0]}, plus one LRU bit. Hit means valid && tag==rd_addr[ADDR_W-1:3]. Byte select is data[rd_addr[2:0]*8 +: 8].
- Edge detect: rd is registered; a request is rd=1 with the previous sample 0, seen at cycle T.
- Ack detect: ack_last is a register; an ack event is mem_ack != ack_last, after which ack_last <= mem_ack.

States:
- INIT (one cycle after reset release): ack_last <= mem_ack; then go to IDLE. This tolerates DDRAM ack polarity after reset.
- IDLE, on request at T:
  - T+1: rd_ready=0 and lookup.
  - Hit: at T+2, rd_ready=1 with rd_data valid; the LRU bit points away from the hit slot.
  - Miss: at T+2, mem_addr=tag, mem_rd toggles, go to DEMAND.
- DEMAND: on an ack event at cycle A, fill the LRU slot; at A+1, rd_ready=1 with rd_data valid; go to IDLE.
- PREFETCH: entered from IDLE when PREFETCH=1, no request is pending, the last served tag is L, and neither slot holds L+1.
  - mem_addr=L+1 (mod 2^(ADDR_W-3), so 0x1FFFFFF wraps to 0); mem_rd toggles.
  - On the ack event, fill the LRU slot; go to IDLE.
- Request during PREFETCH: rd_ready drops at T+1 as normal and the request is latched as pending.
  - On the prefetch ack, the fill completes first, then the pending lookup runs the next cycle.
  - A hit on the just-filled line is served one cycle later; a miss issues a demand fetch.
- Exactly one memory request is outstanding at any time; mem_rd never toggles while awaiting an ack.
- Flush, in any state:
  - Both slots are invalidated and rd_ready=1 the next cycle; any pending demand is dropped.
  - If a fetch is outstanding, go to DRAIN. DRAIN consumes the ack, discards the data (no fill), then goes to IDLE.
  - A flush in INIT is ignored (slots are already invalid).
  - A request arriving during DRAIN is held until DRAIN exits, then processed from IDLE.
- A request and flush in the same cycle: flush wins, and the request is discarded.
- Reset mid-fetch: all state clears immediately, and a late ack after INIT is not misread. The surrounding design resets DDRAM state alongside this block.

Test Plan:
- Sequential reads at byte addresses 0x000..0x00F with a DDRAM model of 10-cycle latency: the first byte completes via DEMAND with mem_addr=0, and a prefetch of mem_addr=1 follows. Bytes 0x008..0x00F are served as hits two cycles after each rd rise. Data equals the model pattern.
- Miss latency: with an empty cache, a read of 0x1234 causes mem_rd to toggle at T+2 with mem_addr=0x246; rd_ready=1 and rd_data equals model byte 4 at ack+1.
- A request to 0x5000 issued while a prefetch of line 0x003 is outstanding: the prefetch fill completes, then a demand for 0x A00 is issued. mem_rd toggles exactly twice in total and never while awaiting an ack.
- Wrap: a read of 0xFFFFFFF causes a prefetch of mem_addr=0; a following read of 0x0000003 hits.
- Flush while a demand is outstanding: rd_ready=1 next cycle, the late ack produces no fill, and a reread of the same address issues a new mem_rd toggle.
- Reset: assert reset_n=0 mid-DEMAND with mem_ack=1 held. After release, the block stays in INIT one cycle with rd_ready=1 and mem_rd=0, and no spurious fill or ready occurs.
